// File: rtl/gps_acq_controller_if.sv
// Control/status bus between the acquisition sequencer and the correlator,
// doppler and max-index datapath.
interface gps_acq_controller_if;
  logic        start;
  logic        abort;
  logic        dump_flag;
  logic [7:0]  max_id;
  logic [31:0] max_sum;
  logic [31:0] threshold;
  logic [9:0]  phase;
  logic [31:0] doppler_tw;
  logic        busy;
  logic        locked;
  logic        fail;
  logic [7:0]  lock_id;
  logic [31:0] best_sum;
  logic [9:0]  best_phase;

  modport master (
    output start, abort, dump_flag, max_id, max_sum, threshold,
    input  phase, doppler_tw, busy, locked, fail, lock_id, best_sum, best_phase
  );

  modport slave (
    input  start, abort, dump_flag, max_id, max_sum, threshold,
    output phase, doppler_tw, busy, locked, fail, lock_id, best_sum, best_phase
  );
endinterface

// File: rtl/gps_acq_controller.sv
// Acquisition sequencer: sweeps code-phase windows and doppler bins, samples the
// correlator peak once per accumulation period and confirms a detection into lock.
module gps_acq_controller #(
  parameter int          NUM_BINS  = 5,
  parameter logic [31:0] TW_MIN    = 32'h0000_0000,
  parameter logic [31:0] TW_STEP   = 32'h0000_0100,
  parameter int          WIN_STEP  = 32,
  parameter int          CONFIRM_N = 3
) (
  input logic                 CLK_16M,
  input logic                 RST,
  gps_acq_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_DWELL   = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  localparam logic [10:0] WIN_STEP_C  = 11'(WIN_STEP);
  localparam logic [10:0] PHASE_MAX_C = 11'd1022;
  localparam logic [7:0]  LAST_BIN_C  = 8'(NUM_BINS - 1);
  localparam logic [3:0]  CONFIRM_C   = 4'(CONFIRM_N);

  state_t      state_r, state_s;
  logic        dump_d_r;
  logic [9:0]  phase_r, phase_s;
  logic [31:0] tw_r, tw_s;
  logic [7:0]  bin_r, bin_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        busy_r, busy_s;
  logic        locked_r, locked_s;
  logic        fail_r, fail_s;
  logic [7:0]  lock_id_r, lock_id_s;
  logic [31:0] best_sum_r, best_sum_s;
  logic [9:0]  best_phase_r, best_phase_s;

  logic        ev_s;
  logic        above_thr_s;
  logic        above_best_s;
  logic [10:0] phase_sum_s;
  logic [3:0]  cnt_inc_s;

  // A period end that coincides with a start/abort pulse belongs to the old configuration.
  assign ev_s         = bus.dump_flag & ~dump_d_r & ~bus.start & ~bus.abort;
  assign above_thr_s  = $signed(bus.max_sum) > $signed(bus.threshold);
  assign above_best_s = $signed(bus.max_sum) > $signed(best_sum_r);
  assign phase_sum_s  = {1'b0, phase_r} + WIN_STEP_C;
  assign cnt_inc_s    = cnt_r + 4'd1;

  // Next-state and next-output logic of the search sequencer.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    tw_s         = tw_r;
    bin_s        = bin_r;
    cnt_s        = cnt_r;
    busy_s       = busy_r;
    locked_s     = locked_r;
    fail_s       = fail_r;
    lock_id_s    = lock_id_r;
    best_sum_s   = best_sum_r;
    best_phase_s = best_phase_r;
    if (bus.abort) begin
      state_s  = ST_IDLE;
      busy_s   = 1'b0;
      locked_s = 1'b0;
      fail_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          if (bus.start) begin
            state_s      = ST_SETTLE;
            phase_s      = 10'd0;
            tw_s         = TW_MIN;
            bin_s        = 8'd0;
            cnt_s        = 4'd0;
            best_sum_s   = 32'h8000_0000;
            best_phase_s = 10'd0;
            locked_s     = 1'b0;
            fail_s       = 1'b0;
            busy_s       = 1'b1;
          end else begin
            state_s = state_r;
          end
        end
        ST_SETTLE: begin
          if (ev_s) begin
            state_s = ST_DWELL;
          end else begin
            state_s = ST_SETTLE;
          end
        end
        ST_DWELL: begin
          if (ev_s) begin
            if (above_best_s) begin
              best_sum_s   = bus.max_sum;
              best_phase_s = phase_r;
            end else begin
              best_sum_s = best_sum_r;
            end
            if (above_thr_s) begin
              lock_id_s = bus.max_id;
              cnt_s     = 4'd1;
              if (CONFIRM_C == 4'd1) begin
                state_s  = ST_LOCKED;
                locked_s = 1'b1;
                busy_s   = 1'b0;
              end else begin
                state_s = ST_CONFIRM;
              end
            end else begin
              state_s = ST_ADVANCE;
            end
          end else begin
            state_s = ST_DWELL;
          end
        end
        ST_CONFIRM: begin
          if (ev_s) begin
            if (above_thr_s) begin
              cnt_s = cnt_inc_s;
              if (cnt_inc_s == CONFIRM_C) begin
                state_s  = ST_LOCKED;
                locked_s = 1'b1;
                busy_s   = 1'b0;
              end else begin
                state_s = ST_CONFIRM;
              end
            end else begin
              state_s = ST_ADVANCE;
            end
          end else begin
            state_s = ST_CONFIRM;
          end
        end
        ST_ADVANCE: begin
          if (phase_sum_s <= PHASE_MAX_C) begin
            phase_s = phase_sum_s[9:0];
            state_s = ST_SETTLE;
          end else begin
            // Window sweep exhausted for this bin: move to the next doppler bin or give up.
            phase_s = 10'd0;
            if (bin_r < LAST_BIN_C) begin
              bin_s   = bin_r + 8'd1;
              tw_s    = tw_r + TW_STEP;
              state_s = ST_SETTLE;
            end else begin
              state_s = ST_FAIL;
              fail_s  = 1'b1;
              busy_s  = 1'b0;
            end
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, edge-detect and output registers.
  always_ff @(posedge CLK_16M or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      dump_d_r     <= 1'b0;
      phase_r      <= 10'd0;
      tw_r         <= TW_MIN;
      bin_r        <= 8'd0;
      cnt_r        <= 4'd0;
      busy_r       <= 1'b0;
      locked_r     <= 1'b0;
      fail_r       <= 1'b0;
      lock_id_r    <= 8'd0;
      best_sum_r   <= 32'd0;
      best_phase_r <= 10'd0;
    end else begin
      state_r      <= state_s;
      dump_d_r     <= bus.dump_flag;
      phase_r      <= phase_s;
      tw_r         <= tw_s;
      bin_r        <= bin_s;
      cnt_r        <= cnt_s;
      busy_r       <= busy_s;
      locked_r     <= locked_s;
      fail_r       <= fail_s;
      lock_id_r    <= lock_id_s;
      best_sum_r   <= best_sum_s;
      best_phase_r <= best_phase_s;
    end
  end

  assign bus.phase      = phase_r;
  assign bus.doppler_tw = tw_r;
  assign bus.busy       = busy_r;
  assign bus.locked     = locked_r;
  assign bus.fail       = fail_r;
  assign bus.lock_id    = lock_id_r;
  assign bus.best_sum   = best_sum_r;
  assign bus.best_phase = best_phase_r;

endmodule

// File: tb/tb_gps_acq_controller.sv
// Randomized bench for gps_acq_controller: an event-level search model predicts every
// output change; a forked monitor compares each observed change against that queue.
module tb_gps_acq_controller;
  localparam int          NUM_BINS  = 5;
  localparam logic [31:0] TW_MIN    = 32'h0000_0000;
  localparam logic [31:0] TW_STEP   = 32'h0000_0100;
  localparam int          WIN_STEP  = 32;
  localparam int          CONFIRM_N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gps_acq_controller_if bus();

  gps_acq_controller #(
    .NUM_BINS(NUM_BINS), .TW_MIN(TW_MIN), .TW_STEP(TW_STEP),
    .WIN_STEP(WIN_STEP), .CONFIRM_N(CONFIRM_N)
  ) dut (
    .CLK_16M(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [9:0]  phase;
    logic [31:0] tw;
    logic        busy;
    logic        locked;
    logic        fail;
    logic [7:0]  lock_id;
    logic [31:0] best_sum;
    logic [9:0]  best_phase;
  } snap_t;

  snap_t exp_q[$];
  snap_t m_last;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;

  // Search model: position in the sweep plus what the next period means.
  logic [9:0]  m_phase;
  logic [31:0] m_tw;
  int          m_bin;
  bit          m_busy, m_locked, m_fail, m_skip;
  int          m_hits;
  logic [7:0]  m_lock_id;
  logic [31:0] m_best;
  logic [9:0]  m_best_phase;
  logic [31:0] thr;

  function automatic snap_t model_snap();
    snap_t s;
    s.phase = m_phase; s.tw = m_tw; s.busy = m_busy; s.locked = m_locked;
    s.fail = m_fail; s.lock_id = m_lock_id; s.best_sum = m_best; s.best_phase = m_best_phase;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.phase = bus.phase; s.tw = bus.doppler_tw; s.busy = bus.busy; s.locked = bus.locked;
    s.fail = bus.fail; s.lock_id = bus.lock_id; s.best_sum = bus.best_sum; s.best_phase = bus.best_phase;
    return s;
  endfunction

  function automatic void push_snap();
    snap_t s;
    s = model_snap();
    if (s != m_last) begin
      exp_q.push_back(s);
      m_last = s;
    end
  endfunction

  function automatic void m_reset(input bit do_push);
    m_phase = 10'd0; m_tw = TW_MIN; m_bin = 0; m_busy = 1'b0; m_locked = 1'b0;
    m_fail = 1'b0; m_skip = 1'b0; m_hits = 0; m_lock_id = 8'd0; m_best = 32'd0; m_best_phase = 10'd0;
    if (do_push) push_snap();
    else m_last = model_snap();
  endfunction

  function automatic void m_start();
    if (!m_busy) begin
      m_phase = 10'd0; m_tw = TW_MIN; m_bin = 0; m_best = 32'h8000_0000; m_best_phase = 10'd0;
      m_locked = 1'b0; m_fail = 1'b0; m_busy = 1'b1; m_skip = 1'b1; m_hits = 0;
      push_snap();
    end
  endfunction

  function automatic void m_abort();
    m_busy = 1'b0; m_locked = 1'b0; m_fail = 1'b0; m_hits = 0;
    push_snap();
  endfunction

  // One accumulation period ends: the first period of each window is thrown away, the
  // first kept one competes for best and may open a detection, later ones confirm it.
  function automatic void m_event(input logic [7:0] id, input logic [31:0] sum);
    int np;
    if (!m_busy) return;
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    if (m_hits == 0 && $signed(sum) > $signed(m_best)) begin
      m_best = sum;
      m_best_phase = m_phase;
    end
    if ($signed(sum) > $signed(thr)) begin
      if (m_hits == 0) m_lock_id = id;
      m_hits++;
      if (m_hits == CONFIRM_N) begin
        m_busy = 1'b0;
        m_locked = 1'b1;
      end
      push_snap();
    end else begin
      push_snap();
      m_hits = 0;
      m_skip = 1'b1;
      np = int'(m_phase) + WIN_STEP;
      if (np <= 1022) begin
        m_phase = 10'(np);
      end else begin
        m_phase = 10'd0;
        if (m_bin < NUM_BINS - 1) begin
          m_bin++;
          m_tw = m_tw + TW_STEP;
        end else begin
          m_busy = 1'b0;
          m_fail = 1'b1;
        end
      end
      push_snap();
    end
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endfunction

  task automatic monitor();
    snap_t prev, cur, e;
    prev = dut_snap();
    forever begin
      @(negedge clk);
      cur = dut_snap();
      if (mon_en && cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change got=%h expected=no change", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL output_change got=%h expected=%h", cur, e);
          end
        end
      end
      prev = cur;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_event(input logic [7:0] id, input logic [31:0] sum, input int hold);
    bus.max_id = id;
    bus.max_sum = sum;
    bus.dump_flag = 1'b1;
    m_event(id, sum);
    repeat (hold) tick();
    bus.dump_flag = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse(input bit s, input bit a, input bit ev);
    bus.start = s;
    bus.abort = a;
    bus.dump_flag = ev;
    if (a) m_abort();
    else if (s) m_start();
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.dump_flag = 1'b0;
    repeat (2) tick();
  endtask

  function automatic logic [31:0] low_sum();
    int v;
    case ($urandom_range(0, 3))
      0:       v = 500;
      1:       v = -int'($urandom_range(1, 1000));
      default: v = int'($urandom_range(0, 499));
    endcase
    return 32'(v);
  endfunction

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.dump_flag = 1'b0;
    bus.max_id = 8'd0; bus.max_sum = 32'd0; bus.threshold = 32'd0;
    thr = 32'd0;
    m_reset(1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_phase", 32'(bus.phase), 32'd0);
    check("reset_tw", bus.doppler_tw, TW_MIN);
    check("reset_flags", {29'd0, bus.busy, bus.locked, bus.fail}, 32'd0);
    check("reset_best", bus.best_sum, 32'd0);
    fork
      monitor();
    join_none
    mon_en = 1'b1;

    // Idle: periods without a start change nothing.
    repeat (3) do_event(8'($urandom), $urandom, 2);

    // Full sweep with an unreachable threshold.
    thr = 32'h7FFF_FFFF;
    bus.threshold = thr;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 320; i++)
      do_event(8'($urandom), $urandom & 32'hFFFF_FFF0, (i % 37 == 0) ? 10 : int'($urandom_range(1, 4)));
    check("sweep_fail", 32'(bus.fail), 32'd1);
    check("sweep_busy", 32'(bus.busy), 32'd0);
    check("sweep_tw", bus.doppler_tw, TW_MIN + 32'd4 * TW_STEP);
    repeat (2) do_event(8'($urandom), 32'h7FFF_FFFF, 1);

    // Lock on window 96 of bin 2.
    thr = 32'd500;
    bus.threshold = thr;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && m_busy; i++)
      do_event(8'($urandom), (m_phase == 10'd96 && m_bin == 2) ? 32'd1000 : low_sum(), 1);
    check("lock_locked", 32'(bus.locked), 32'd1);
    check("lock_phase", 32'(bus.phase), 32'd96);
    check("lock_tw", bus.doppler_tw, TW_MIN + 32'd512);
    check("lock_id", 32'(bus.lock_id), 32'(m_lock_id));
    repeat (3) do_event(8'($urandom), 32'd1000, 2);

    // False alarm at window 64 of bin 0, then the search runs out.
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && m_busy; i++)
      do_event(8'($urandom), (m_bin == 0 && m_phase == 10'd64 && m_hits == 0) ? 32'd1000 : low_sum(), 1);
    check("falarm_locked", 32'(bus.locked), 32'd0);
    check("falarm_fail", 32'(bus.fail), 32'd1);

    // Abort and start together while confirming, with a coinciding period end.
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && m_hits == 0; i++)
      do_event(8'($urandom), (m_phase == 10'd32) ? 32'd1000 : low_sum(), 1);
    pulse(1'b1, 1'b1, 1'b1);
    check("race_busy", 32'(bus.busy), 32'd0);
    check("race_locked", 32'(bus.locked), 32'd0);
    repeat (2) do_event(8'($urandom), 32'd1000, 1);
    pulse(1'b1, 1'b0, 1'b1);
    check("restart_best", bus.best_sum, 32'h8000_0000);
    check("restart_phase", 32'(bus.phase), 32'd0);

    // Random mix of periods, starts and aborts.
    thr = 32'($urandom_range(0, 2000));
    bus.threshold = thr;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0:       pulse(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        1:       pulse(1'b0, 1'b1, 1'b0);
        default: do_event(8'($urandom), 32'(int'($urandom_range(0, 3000)) - 500), int'($urandom_range(1, 3)));
      endcase
    end

    // Reset in the middle of a dwell.
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    do_event(8'd1, 32'd7, 1);
    m_reset(1'b1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    repeat (2) do_event(8'($urandom), 32'd1000, 1);

    repeat (5) tick();
    check("pending_changes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
